// File: rtl/conv_window_sequencer.sv
// Feeds a sliding LEN-deep sample window plus a latched kernel to a dot-product operator
// and forwards each operator result downstream in order, flagging the last one of a frame.
module conv_window_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN*WIDTH-1:0]   cfg_kernel_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [WIDTH-1:0]       in_data_i,
    input  logic                   in_valid_i,
    input  logic                   in_last_i,
    output logic                   in_ready_o,
    output logic [LEN*WIDTH-1:0]   op_kernel_o,
    output logic [LEN*WIDTH-1:0]   op_data_o,
    output logic                   op_valid_o,
    input  logic                   op_ready_i,
    input  logic [2*WIDTH-1:0]     op_result_i,
    input  logic                   op_out_valid_i,
    output logic                   op_out_ready_o,
    output logic [2*WIDTH-1:0]     out_result_o,
    output logic                   out_valid_o,
    output logic                   out_last_o,
    input  logic                   out_ready_i
);

    localparam int unsigned CW = $clog2(LEN) + 1;

    typedef enum logic [2:0] {StIdle, StFill, StIssue, StWait, StEmit, StSlide} state_e;

    state_e                       state_q;
    logic [LEN-1:0][WIDTH-1:0]    win_q;
    logic [LEN-1:0][WIDTH-1:0]    shift_win;
    logic [LEN-1:0][WIDTH-1:0]    short_win;
    logic [LEN*WIDTH-1:0]         kernel_q;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_inc;
    logic                         ending_q;
    logic [2*WIDTH-1:0]           result_q;
    logic                         cfg_ready_q;
    logic                         in_ready_q;
    logic                         op_valid_q;
    logic                         op_out_ready_q;
    logic                         out_valid_q;
    logic                         out_last_q;
    int                           gap;

    // A short frame is realigned so its real samples start at element 0, zero padded above.
    always_comb begin
        shift_win = {in_data_i, win_q[LEN-1:1]};
        cnt_inc   = cnt_q + 1'b1;
        gap       = int'(LEN) - int'(cnt_inc);
        short_win = '0;
        for (int i = 0; i < int'(LEN); i++) begin
            if (i + gap < int'(LEN)) begin
                short_win[i] = shift_win[i + gap];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            win_q          <= '0;
            kernel_q       <= '0;
            cnt_q          <= '0;
            ending_q       <= 1'b0;
            result_q       <= '0;
            cfg_ready_q    <= 1'b1;
            in_ready_q     <= 1'b0;
            op_valid_q     <= 1'b0;
            op_out_ready_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid_i && cfg_ready_q) begin
                        kernel_q    <= cfg_kernel_i;
                        win_q       <= '0;
                        cnt_q       <= '0;
                        ending_q    <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    if (in_valid_i && in_ready_q) begin
                        win_q <= in_last_i ? short_win : shift_win;
                        cnt_q <= cnt_inc;
                        if (in_last_i || cnt_inc == CW'(LEN)) begin
                            ending_q   <= in_last_i;
                            in_ready_q <= 1'b0;
                            op_valid_q <= 1'b1;
                            state_q    <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (op_ready_i) begin
                        op_valid_q     <= 1'b0;
                        op_out_ready_q <= 1'b1;
                        state_q        <= StWait;
                    end
                end
                StWait: begin
                    if (op_out_valid_i) begin
                        result_q       <= op_result_i;
                        op_out_ready_q <= 1'b0;
                        out_valid_q    <= 1'b1;
                        out_last_q     <= ending_q;
                        state_q        <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (ending_q) begin
                            cfg_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= StSlide;
                        end
                    end
                end
                StSlide: begin
                    if (in_valid_i) begin
                        win_q      <= shift_win;
                        ending_q   <= in_last_i;
                        in_ready_q <= 1'b0;
                        op_valid_q <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_ready_o    = cfg_ready_q;
    assign in_ready_o     = in_ready_q;
    assign op_kernel_o    = kernel_q;
    assign op_data_o      = win_q;
    assign op_valid_o     = op_valid_q;
    assign op_out_ready_o = op_out_ready_q;
    assign out_result_o   = result_q;
    assign out_valid_o    = out_valid_q;
    assign out_last_o     = out_last_q;

endmodule
